// File: rtl/var_clk_borrow_ctrl.sv
// Variable-delay clock sequencer: origin phase by default, leading phase
// (borrow) for a bounded hold after repeated timing errors. Option: VAR_CLK_STATS_EN.
module var_clk_borrow_ctrl #(
  parameter int CNT_W  = 4,
  parameter int WIN_W  = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              err_pulse,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic [WIN_W-1:0]  cfg_window,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [HOLD_W-1:0] cfg_cool,
  output logic              mode,
  output logic              delay_sel,
  output logic              borrow_active,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [1:0]        state_o
`ifdef VAR_CLK_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_borrows,
  output logic [15:0]       stat_errs
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    BORROW  = 2'd2,
    COOL    = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic mode_q, sel_q, bor_q;

  logic [CNT_W:0]    err_sum;
  logic [CNT_W-1:0]  err_sat;
  logic [CNT_W-1:0]  thr_eff;
  logic              hit;
  logic              expire;
  logic [HOLD_W-1:0] hold_ld;
  logic [HOLD_W-1:0] cool_ld;

  // Threshold, window-expiry and latch-value helpers
  always_comb begin
    err_sum = {1'b0, err_q} + {{CNT_W{1'b0}}, err_pulse};
    err_sat = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    thr_eff = (cfg_thresh == '0) ? CNT_W'(1) : cfg_thresh;
    hit     = err_sum >= {1'b0, thr_eff};
    expire  = (cfg_window != '0) &&
              (win_q >= cfg_window - WIN_W'(1));
    hold_ld = (cfg_hold == '0) ? '0 : cfg_hold - HOLD_W'(1);
    cool_ld = cfg_cool - HOLD_W'(1);
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = IDLE;
      err_d   = '0;
      win_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = MONITOR;
          err_d   = '0;
          win_d   = '0;
        end
        MONITOR: begin
          if (hit) begin
            state_d = BORROW;
            err_d   = err_sat;
            win_d   = '0;
            cnt_d   = hold_ld;
          end else if (expire) begin
            err_d = '0;
            win_d = '0;
          end else begin
            err_d = err_sat;
            if (cfg_window != '0) win_d = win_q + WIN_W'(1);
          end
        end
        BORROW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLD_W'(1);
          end else if (cfg_cool == '0) begin
            state_d = MONITOR;
            err_d   = '0;
            win_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = COOL;
            cnt_d   = cool_ld;
          end
        end
        COOL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLD_W'(1);
          end else begin
            state_d = MONITOR;
            err_d   = '0;
            win_d   = '0;
          end
        end
      endcase
    end
  end

  // State, counters and glitch-free cell controls registered from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      sel_q   <= 1'b1;
      bor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      mode_q  <= (state_d != IDLE);
      sel_q   <= (state_d != BORROW);
      bor_q   <= (state_d == BORROW);
    end
  end

  assign mode          = mode_q;
  assign delay_sel     = sel_q;
  assign borrow_active = bor_q;
  assign err_cnt       = err_q;
  assign state_o       = state_q;

`ifdef VAR_CLK_STATS_EN
  logic [15:0] sb_q, se_q;
  logic        bor_entry;

  assign bor_entry = (state_q == MONITOR) && (state_d == BORROW);

  // Saturating borrow-entry and error statistics; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
      se_q <= '0;
    end else if (stat_clr) begin
      sb_q <= '0;
      se_q <= '0;
    end else begin
      if (bor_entry && sb_q != 16'hFFFF) sb_q <= sb_q + 16'd1;
      if (en && err_pulse && se_q != 16'hFFFF) se_q <= se_q + 16'd1;
    end
  end

  assign stat_borrows = sb_q;
  assign stat_errs    = se_q;
`else
`endif

endmodule

// File: tb/tb_var_clk_borrow_ctrl.sv
// Directed bench for var_clk_borrow_ctrl with a cycle-level reference model.
// Define VAR_CLK_STATS_EN to also exercise the statistics counters.
module tb_var_clk_borrow_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       err_pulse;
  logic [3:0] cfg_thresh;
  logic [7:0] cfg_window;
  logic [7:0] cfg_hold;
  logic [7:0] cfg_cool;
  logic       mode, delay_sel, borrow_active;
  logic [3:0] err_cnt;
  logic [1:0] state_o;
`ifdef VAR_CLK_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_borrows, stat_errs;
`endif

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  int m_st = 0, m_err = 0, m_age = 0, m_left = 0;
`ifdef VAR_CLK_STATS_EN
  int s_err = 0, s_bor = 0;
`endif

  always #5 clk = ~clk;

  var_clk_borrow_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .err_pulse(err_pulse),
    .cfg_thresh(cfg_thresh),
    .cfg_window(cfg_window),
    .cfg_hold(cfg_hold),
    .cfg_cool(cfg_cool),
    .mode(mode),
    .delay_sel(delay_sel),
    .borrow_active(borrow_active),
    .err_cnt(err_cnt),
    .state_o(state_o)
`ifdef VAR_CLK_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat_borrows(stat_borrows),
    .stat_errs(stat_errs)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: phase plus remaining-cycles and window-age bookkeeping
  always @(posedge clk or negedge rst_n) begin : mdl
    int st, er, ag, lf, th, tot;
    if (!rst_n) begin
      m_st <= 0; m_err <= 0; m_age <= 0; m_left <= 0;
`ifdef VAR_CLK_STATS_EN
      s_err <= 0; s_bor <= 0;
`endif
    end else begin
      st = m_st; er = m_err; ag = m_age; lf = m_left;
      if (!en) begin
        st = 0; er = 0; ag = 0; lf = 0;
      end else begin
        case (m_st)
          0: begin st = 1; er = 0; ag = 0; end
          1: begin
            th  = (cfg_thresh == 0) ? 1 : int'(cfg_thresh);
            tot = m_err + int'(err_pulse);
            if (tot >= th) begin
              st = 2; ag = 0;
              lf = (cfg_hold == 0) ? 1 : int'(cfg_hold);
              er = (tot > 15) ? 15 : tot;
            end else if (cfg_window != 0 && m_age + 1 >= int'(cfg_window)) begin
              er = 0; ag = 0;
            end else begin
              er = (tot > 15) ? 15 : tot;
              ag = (cfg_window == 0) ? 0 : m_age + 1;
            end
          end
          2: begin
            lf = m_left - 1;
            if (lf == 0) begin
              if (cfg_cool == 0) begin st = 1; er = 0; ag = 0; end
              else begin st = 3; lf = int'(cfg_cool); end
            end
          end
          3: begin
            lf = m_left - 1;
            if (lf == 0) begin st = 1; er = 0; ag = 0; end
          end
          default: st = 0;
        endcase
      end
`ifdef VAR_CLK_STATS_EN
      if (stat_clr) begin
        s_err <= 0; s_bor <= 0;
      end else begin
        if (en && err_pulse && s_err < 65535) s_err <= s_err + 1;
        if (m_st == 1 && st == 2 && s_bor < 65535) s_bor <= s_bor + 1;
      end
`endif
      m_st <= st; m_err <= er; m_age <= ag; m_left <= lf;
    end
  end

  // Compare every cycle away from the active edge
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("m_mode", int'(mode), int'(m_st != 0));
      chk("m_sel", int'(delay_sel), int'(m_st != 2));
      chk("m_borrow", int'(borrow_active), int'(m_st == 2));
      chk("m_state", int'(state_o), m_st);
      chk("m_errcnt", int'(err_cnt), m_err);
`ifdef VAR_CLK_STATS_EN
      chk("m_stat_errs", int'(stat_errs), s_err);
      chk("m_stat_bor", int'(stat_borrows), s_bor);
`endif
    end
  end

  task automatic cyc(input logic ep);
    err_pulse = ep;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; err_pulse = 1'b0;
    cfg_thresh = 4'd3; cfg_window = 8'd16;
    cfg_hold = 8'd4; cfg_cool = 8'd2;
`ifdef VAR_CLK_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    // 1: reset values
    chk("rst_mode", int'(mode), 0);
    chk("rst_sel", int'(delay_sel), 1);
    chk("rst_state", int'(state_o), 0);
    chk("rst_errcnt", int'(err_cnt), 0);
    chk("rst_borrow", int'(borrow_active), 0);
    rst_n = 1'b1;
    run_cmp = 1'b1;
    cyc(0);
    chk("idle_hold", int'(state_o), 0);
    en = 1'b1;
    cyc(0);
    chk("en_monitor", int'(state_o), 1);
    chk("en_mode", int'(mode), 1);

    // 2: three errors -> borrow 4 cycles, cool 2, back to monitor
    cyc(1); cyc(0); cyc(1); cyc(0);
    chk("pre_thr_cnt", int'(err_cnt), 2);
    chk("pre_thr_sel", int'(delay_sel), 1);
    cyc(1);
    chk("bor_sel0", int'(delay_sel), 0);
    chk("bor_state", int'(state_o), 2);
    chk("bor_active", int'(borrow_active), 1);
    cyc(1);
    chk("bor_sel1", int'(delay_sel), 0);
    cyc(1);
    chk("bor_sel2", int'(delay_sel), 0);
    cyc(0);
    chk("bor_sel3", int'(delay_sel), 0);
    cyc(0);
    chk("cool_state0", int'(state_o), 3);
    chk("cool_sel0", int'(delay_sel), 1);
    cyc(0);
    chk("cool_state1", int'(state_o), 3);
    cyc(0);
    chk("back_mon", int'(state_o), 1);
    chk("back_cnt", int'(err_cnt), 0);

`ifdef VAR_CLK_STATS_EN
    // 6: 5 errors incl. 2 in BORROW, one borrow; clear wins over increment
    chk("st_errs5", int'(stat_errs), 5);
    chk("st_bor1", int'(stat_borrows), 1);
    stat_clr = 1'b1;
    cyc(1);
    stat_clr = 1'b0;
    chk("st_clr_errs", int'(stat_errs), 0);
    chk("st_clr_bor", int'(stat_borrows), 0);
`endif

    // 3: window wrap prevents borrow
    cfg_window = 8'd8;
    en = 1'b0; cyc(0);
    en = 1'b1; cyc(0);
    cyc(1); cyc(1);
    repeat (5) cyc(0);
    chk("win_pre_wrap", int'(err_cnt), 2);
    cyc(0);
    chk("win_wrapped", int'(err_cnt), 0);
    cyc(1); cyc(1);
    chk("win_cnt2", int'(err_cnt), 2);
    chk("win_no_bor", int'(state_o), 1);

    // 4: error on exact expiry cycle still triggers borrow
    repeat (5) cyc(0);
    chk("exp_cnt", int'(err_cnt), 2);
    cyc(1);
    chk("exp_borrow", int'(state_o), 2);
    chk("exp_sel", int'(delay_sel), 0);

    // 5: en drop on 2nd borrow cycle
    cyc(0);
    chk("bor2_state", int'(state_o), 2);
    en = 1'b0;
    cyc(0);
    chk("en0_mode", int'(mode), 0);
    chk("en0_sel", int'(delay_sel), 1);
    chk("en0_state", int'(state_o), 0);

    // zero thresh/hold/cool act as 1/1/none
    cfg_thresh = 4'd0; cfg_hold = 8'd0; cfg_cool = 8'd0;
    en = 1'b1; cyc(0);
    cyc(1);
    chk("z_borrow", int'(state_o), 2);
    cyc(0);
    chk("z_back_mon", int'(state_o), 1);

    // window=0 never expires
    cfg_thresh = 4'd4; cfg_window = 8'd0;
    cyc(1); cyc(1); cyc(1);
    repeat (20) cyc(0);
    chk("nowin_cnt", int'(err_cnt), 3);

    // asynchronous reset in the middle of a borrow
    cfg_hold = 8'd4;
    cyc(1);
    chk("ar_borrow", int'(state_o), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_mode", int'(mode), 0);
    chk("ar_sel", int'(delay_sel), 1);
    chk("ar_state", int'(state_o), 0);
    chk("ar_borrow0", int'(borrow_active), 0);
    chk("ar_cnt", int'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0);
    cyc(0);
    chk("ar_resume", int'(state_o), 1);

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
